// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: shared state encoding and default width for the bit-serial adder.
package bit_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/bit_serial_adder_full_adder_bit.sv
// full_adder_bit: single full-adder cell, XOR sum and majority carry, matching the downstream netlist cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: latches two operands and a carry, then adds them LSB-first through one full-adder cell.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_c,
  output logic             ser_sum
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, s, co;
  full_adder_bit u_fa (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(s), .co(co));
  // New sum bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
  if (WIDTH == 1) begin : g_sh1
    assign sum_sh = s;
  end else begin : g_shn
    assign sum_sh = {s, sum_q[WIDTH-1:1]};
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE && start) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = cin;
      cnt_d   = '0;
      sum_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = co;
      cnt_d   = cnt_q + CW'(1);
      sum_d   = sum_sh;
      state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
      cout_d  = (cnt_q == CW'(WIDTH - 1)) ? co : cout_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ser_a   = a_q[0];
  assign ser_b   = b_q[0];
  assign ser_c   = carry_q;
  assign ser_sum = s;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: checks WIDTH=8, 13 and 1 instances side by side against a plain-arithmetic reference.
module tb_bit_serial_adder;
  logic        clk = 1'b0, rst, start, cin;
  logic [31:0] a, b;
  logic        busy8, done8, cout8, sa8, sb8, sc8, ss8;
  logic [7:0]  sum8;
  logic        busy13, done13, cout13, sa13, sb13, sc13, ss13;
  logic [12:0] sum13;
  logic        busy1, done1, cout1, sa1, sb1, sc1, ss1;
  logic [0:0]  sum1;
  logic [31:0] sum_v [3];
  logic        busy_v [3], done_v [3], cout_v [3], sa_v [3], sb_v [3], sc_v [3], ss_v [3];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start), .a_in(a[7:0]), .b_in(b[7:0]),
    .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ser_a(sa8), .ser_b(sb8),
    .ser_c(sc8), .ser_sum(ss8));
  bit_serial_adder #(.WIDTH(13)) u13 (.clk(clk), .rst(rst), .start(start), .a_in(a[12:0]), .b_in(b[12:0]),
    .cin(cin), .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ser_a(sa13), .ser_b(sb13),
    .ser_c(sc13), .ser_sum(ss13));
  bit_serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(start), .a_in(a[0:0]), .b_in(b[0:0]),
    .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ser_a(sa1), .ser_b(sb1),
    .ser_c(sc1), .ser_sum(ss1));

  assign sum_v[0] = 32'(sum8);
  assign sum_v[1] = 32'(sum13);
  assign sum_v[2] = 32'(sum1);
  assign busy_v = '{busy8, busy13, busy1};
  assign done_v = '{done8, done13, done1};
  assign cout_v = '{cout8, cout13, cout1};
  assign sa_v   = '{sa8, sa13, sa1};
  assign sb_v   = '{sb8, sb13, sb1};
  assign sc_v   = '{sc8, sc13, sc1};
  assign ss_v   = '{ss8, ss13, ss1};

  function automatic int wd(input int i);
    return (i == 0) ? 8 : (i == 1) ? 13 : 1;
  endfunction

  task automatic chk(input string nm, input int w, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (WIDTH=%0d): got %0h, expected %0h", nm, w, got, exp);
    end
  endtask

  // n = cycles since the accepting edge; expectations come from ordinary integer addition.
  task automatic check_cycle(input int i, input int n, input logic [31:0] x, input logic [31:0] y, input logic c);
    int          w, k;
    logic [63:0] m, mk, r;
    w = wd(i);
    m = (64'd1 << w) - 1;
    r = (x & m) + (y & m) + 64'(c);
    chk("busy", w, 64'(busy_v[i]), 64'(n >= 1 && n <= w + 1));
    chk("done", w, 64'(done_v[i]), 64'(n == w + 1));
    if (n >= 1 && n <= w) begin
      k  = n - 1;
      mk = (64'd1 << k) - 1;
      chk("ser_a", w, 64'(sa_v[i]), 64'(x[k]));
      chk("ser_b", w, 64'(sb_v[i]), 64'(y[k]));
      chk("ser_c", w, 64'(sc_v[i]), (((x & mk) + (y & mk) + 64'(c)) >> k) & 1);
      chk("ser_sum", w, 64'(ss_v[i]), (r >> k) & 1);
    end
    if (n > w) begin
      chk("sum", w, 64'(sum_v[i]), r & m);
      chk("cout", w, 64'(cout_v[i]), (r >> w) & 1);
    end
  endtask

  task automatic chk_zero();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", wd(i), 64'(busy_v[i]), 0);
      chk("rst_done", wd(i), 64'(done_v[i]), 0);
      chk("rst_sum", wd(i), 64'(sum_v[i]), 0);
      chk("rst_cout", wd(i), 64'(cout_v[i]), 0);
      chk("rst_ser", wd(i), 64'({sa_v[i], sb_v[i], sc_v[i], ss_v[i]}), 0);
    end
  endtask

  // Operands are scrambled right after the accepting edge to show they are not re-sampled.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_cycle(i, n, x, y, c);
      if (n == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
      end
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] s8;
    logic       co8, s1, co1;
  } vec_t;
  vec_t        vt [7];
  logic [31:0] oa [50], ob [50];
  logic        oc [50];

  initial begin
    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[6] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero();
    rst = 1'b0; start = 1'b0;

    foreach (vt[j]) begin
      do_op(32'(vt[j].a), 32'(vt[j].b), vt[j].c);
      chk("tbl_sum8", 8, 64'(sum8), 64'(vt[j].s8));
      chk("tbl_cout8", 8, 64'(cout8), 64'(vt[j].co8));
      chk("tbl_sum1", 1, 64'(sum1), 64'(vt[j].s1));
      chk("tbl_cout1", 1, 64'(cout1), 64'(vt[j].co1));
    end

    // start held high with fresh operands every cycle: only IDLE-cycle values are taken
    for (int j = 0; j < 50; j++) begin
      oa[j] = $urandom; ob[j] = $urandom; oc[j] = 1'($urandom);
    end
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j >= 1)
        for (int i = 0; i < 3; i++) begin
          int p, k;
          p = wd(i) + 2;
          k = ((j - 1) / p) * p;
          check_cycle(i, j - k, oa[k], ob[k], oc[k]);
        end
      a = oa[j]; b = ob[j]; cin = oc[j]; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // reset during cycle T+4 aborts the operation
    a = 32'h0000_1ABC; b = 32'h0000_0F0F; cin = 1'b1; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) check_cycle(i, n, 32'h0000_1ABC, 32'h0000_0F0F, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero();
    for (int n = 6; n <= 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("no_done_after_rst", wd(i), 64'(done_v[i]), 0);
    end
    do_op(32'h0000_0ABC, 32'h0000_1543, 1'b1);

    for (int j = 0; j < 1000; j++) do_op($urandom, $urandom, 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential front end for the full-adder netlist stage. It latches two WIDTH-bit operands and a carry-in, then streams them LSB-first through a single full-adder bit cell, one bit per clock, with the carry held in a register. The per-bit operand/carry taps go to the downstream XOR/XNOR and carry-out cells. The block also assembles the parallel sum and final carry-out with a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8: operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result register; holds until the next accepted start.
- cout  output  1  final carry; holds like sum.
- ser_a, ser_b, ser_c  output  1 each  current bit of A, current bit of B, and the carry register, driven to the downstream stage; valid while in SHIFT.
- ser_sum  output  1  combinational sum bit of the current cycle.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 loads the A/B shift registers from a_in/b_in, loads carry_q from cin, clears bit counter and sum, then moves to SHIFT. start=0: stay in IDLE.
- SHIFT: cell computes s = a0^b0^carry_q and co = maj(a0,b0,carry_q).
  - s is shifted into sum from the MSB end, so sum is LSB-aligned after WIDTH shifts.
  - carry_q <= co; A and B shift right by one; counter increments.
  - When counter == WIDTH-1, go to DONE and load cout <= co.
- DONE: done=1 for exactly one cycle, then unconditional move to IDLE.
- start in SHIFT or DONE is ignored; it is not queued.
- Arithmetic is modulo 2^WIDTH with the carry out in cout: {cout,sum} = a_in + b_in + cin.
- Counter width is $clog2(WIDTH+1). For WIDTH=1 the block enters SHIFT once, then DONE.
- Operand inputs changing after the start cycle have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry_q=0, shift registers=0, ser_*=0.
- rst dominates every other input in the same cycle. Reset mid-SHIFT aborts the operation: no done pulse, and sum/cout are cleared.
- Start accepted at edge T. SHIFT spans cycles T+1..T+WIDTH, and bit i is processed in cycle T+1+i.
- done=1 during cycle T+WIDTH+1, with sum/cout already valid in that cycle. busy falls in cycle T+WIDTH+2.
- Earliest next accepted start is at edge T+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- ser_a/ser_b/ser_c come straight from registers (no combinational path from the inputs). ser_sum is combinational from those registers.

## Structure
- Shared package bit_serial_adder_pkg:
  - state_t enum (IDLE, SHIFT, DONE), 2 bits.
  - DEFAULT_WIDTH = 8.
- Sub-module full_adder_bit (a, b, ci -> s, co), purely combinational: XOR sum and majority carry. It matches the cell function of the downstream netlist, so equivalence runs can bind to it.
- Top level: FSM, counter, two shift registers, sum register, carry register.

## Test plan
- WIDTH=8: a_in=8'h0F, b_in=8'h01, cin=0, start at T -> done pulse in cycle T+9 with sum=8'h10, cout=0; busy high T+1..T+9.
- a_in=8'hFF, b_in=8'h01, cin=0 -> sum=8'h00, cout=1. a_in=8'hFF, b_in=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously with a new operand pair every cycle:
  - only the IDLE-cycle values are used;
  - second operation accepted at T+10;
  - done pulses exactly every 10 cycles.
- rst asserted in cycle T+4 mid-SHIFT -> next cycle state=IDLE, busy=0, sum=0, cout=0, and no done pulse. A fresh start then completes normally.
- WIDTH=1: a_in=1, b_in=1, cin=1 -> done at T+2, sum=1, cout=1. ser_a/ser_b/ser_c trace checked bit-by-bit against the expected LSB-first sequence.
- Random regression, 1000 operations at WIDTH=8 and WIDTH=13, with {cout,sum} compared to the reference addition.
